gpio_in_filter: RTL and testbench



---
 rtl/gpio_filter_pkg.sv | 15 +
 rtl/gpio_filter_lane.sv | 73 +++++++
 rtl/gpio_in_filter.sv | 36 +++
 tb/tb_gpio_in_filter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_filter_pkg.sv
// rtl/gpio_filter_pkg.sv - shared defaults and types for the GPIO input filter
package gpio_filter_pkg;

    localparam int NB_LANES_DEF    = 32;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_WIDTH_DEF   = 8;

    typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

    // A synchroniser shorter than two flops gives no metastability protection
    function automatic int sync_depth(input int requested);
        return (requested < 2) ? 2 : requested;
    endfunction

endpackage

// File: rtl/gpio_filter_lane.sv
// rtl/gpio_filter_lane.sv - one GPIO lane: synchroniser, glitch filter, edge events (GPIO_FILTER_EVENT_EN)
module gpio_filter_lane
    import gpio_filter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pad,
    input  logic                 lane_en,
    input  logic [CNT_WIDTH-1:0] filt_len,
    output logic                 level,
    output logic                 rise,
    output logic                 fall
);

    localparam int SYNC_N = sync_depth(SYNC_STAGES);

    logic [SYNC_N-1:0]    sync_q;
    logic                 s;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 take;

    assign s = sync_q[SYNC_N-1];

    // The synchronised level has differed long enough to be accepted this cycle
    assign take = lane_en && (s != level) && (cnt >= filt_len);

    // Synchroniser chain; keeps running even when the lane is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], pad};
        end
    end

    // Stability counter and filtered output level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (!lane_en) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s == level) begin
            cnt <= '0;
        end else if (take) begin
            level <= s;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef GPIO_FILTER_EVENT_EN
    // Edge pulses line up with the cycle the filtered level changes; a forced disable is silent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= take & s;
            fall <= take & ~s;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/gpio_in_filter.sv
// rtl/gpio_in_filter.sv - synchronise and glitch-filter GPIO pads onto gpio_in (GPIO_FILTER_EVENT_EN adds edge events)
module gpio_in_filter
    import gpio_filter_pkg::*;
#(
    parameter int NB_LANES    = NB_LANES_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NB_LANES-1:0]  gpio_pad_i,
    input  logic [NB_LANES-1:0]  lane_en_i,
    input  logic [CNT_WIDTH-1:0] filt_len_i,
    output logic [NB_LANES-1:0]  gpio_o,
    output logic [NB_LANES-1:0]  rise_o,
    output logic [NB_LANES-1:0]  fall_o
);

    // One independent filter per lane; threshold and reset are shared
    for (genvar g = 0; g < NB_LANES; g++) begin : g_lane
        gpio_filter_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .pad      (gpio_pad_i[g]),
            .lane_en  (lane_en_i[g]),
            .filt_len (filt_len_i),
            .level    (gpio_o[g]),
            .rise     (rise_o[g]),
            .fall     (fall_o[g])
        );
    end

endmodule

// File: tb/tb_gpio_in_filter.sv
// tb/tb_gpio_in_filter.sv - randomized and directed checks of gpio_in_filter against a reference model
module tb_gpio_in_filter;
    import gpio_filter_pkg::*;

    localparam int NB = 32;
    localparam int SS = 2;
    localparam int CW = 8;
`ifdef GPIO_FILTER_EVENT_EN
    localparam bit EV = 1'b1;
`else
    localparam bit EV = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] pad = '0;
    logic [NB-1:0] en  = '0;
    logic [CW-1:0] filt = '0;
    logic [NB-1:0] gpio;
    logic [NB-1:0] rise;
    logic [NB-1:0] fall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpio_in_filter #(
        .NB_LANES    (NB),
        .SYNC_STAGES (SS),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gpio_pad_i (pad),
        .lane_en_i  (en),
        .filt_len_i (filt),
        .gpio_o     (gpio),
        .rise_o     (rise),
        .fall_o     (fall)
    );

    // Reference: a level is accepted once it has disagreed with the output for more
    // than filt_len consecutive edges since the lane last agreed, was reset or switched.
    logic [NB-1:0] m_out  = '0;
    logic [NB-1:0] m_rise = '0;
    logic [NB-1:0] m_fall = '0;
    logic [NB-1:0] m_s;
    logic [NB-1:0] m_pipe [SS] = '{default: '0};
    int            anchor [NB] = '{default: 0};
    int            tick = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out  = '0;
            m_rise = '0;
            m_fall = '0;
            for (int k = 0; k < SS; k++) m_pipe[k] = '0;
            for (int i = 0; i < NB; i++) anchor[i] = tick;
        end else begin
            tick   = tick + 1;
            m_s    = m_pipe[SS-1];
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < NB; i++) begin
                if (!en[i]) begin
                    m_out[i]  = 1'b0;
                    anchor[i] = tick;
                end else if (m_s[i] == m_out[i]) begin
                    anchor[i] = tick;
                end else if (tick - anchor[i] > int'(filt)) begin
                    m_out[i]  = m_s[i];
                    anchor[i] = tick;
                    if (EV) begin
                        m_rise[i] = m_s[i];
                        m_fall[i] = ~m_s[i];
                    end
                end
            end
            for (int k = SS-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = pad;
        end
    end

    task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("gpio_o", gpio, m_out);
        check("rise_o", rise, m_rise);
        check("fall_o", fall, m_fall);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    initial begin
        // Reset with pads high, then release with no filtering
        rst  = 1'b1;
        pad  = '1;
        filt = '0;
        en   = '1;
        steps(3);
        check("rst_gpio", gpio, '0);
        rst = 1'b0;
        steps(3);
        check("release_gpio", gpio, '1);
        check("release_rise", rise, EV ? '1 : '0);
        step();
        check("release_rise_once", rise, '0);

        // Glitch shorter than threshold, then a pulse that passes
        pad = '0;
        steps(6);
        filt = 8'd5;
        pad[3] = 1'b1;
        steps(4);
        pad[3] = 1'b0;
        steps(10);
        check("glitch_l3", gpio & 32'h8, 32'h0);
        pad[3] = 1'b1;
        steps(7);
        check("pulse_l3_pre", gpio & 32'h8, 32'h0);
        step();
        check("pulse_l3", gpio & 32'h8, 32'h8);
        pad[3] = 1'b0;
        steps(10);

        // Threshold lowered below the running count
        filt = 8'd20;
        pad[0] = 1'b1;
        steps(12);
        check("long_l0", gpio & 32'h1, 32'h0);
        filt = 8'd4;
        step();
        check("lowered_l0", gpio & 32'h1, 32'h1);

        // Disable and re-enable lane 7
        filt = 8'd2;
        pad[7] = 1'b1;
        steps(6);
        check("l7_high", gpio & 32'h80, 32'h80);
        en[7] = 1'b0;
        step();
        check("l7_off", gpio & 32'h80, 32'h0);
        check("l7_off_fall", fall & 32'h80, 32'h0);
        steps(3);
        en[7] = 1'b1;
        steps(2);
        check("l7_reen_pre", gpio & 32'h80, 32'h0);
        step();
        check("l7_reen", gpio & 32'h80, 32'h80);
        check("l7_reen_rise", rise & 32'h80, EV ? 32'h80 : 32'h0);

        // Asynchronous reset in the middle of a count on lane 12
        filt = 8'd10;
        pad[12] = 1'b1;
        steps(5);
        #2 rst = 1'b1;
        #1;
        check("async_gpio", gpio, '0);
        check("async_rise", rise, '0);
        check("async_fall", fall, '0);
        step();
        rst = 1'b0;
        steps(12);
        check("l12_pre", gpio & 32'h1000, 32'h0);
        step();
        check("l12_full", gpio & 32'h1000, 32'h1000);

        // Randomized traffic with sparse pad toggles and occasional reconfiguration
        for (int n = 0; n < 600; n++) begin
            pad = pad ^ ($urandom & $urandom & $urandom);
            if (n % 40 == 0) filt = CW'($urandom_range(0, 6));
            if (n % 75 == 0) en = ~($urandom & $urandom & $urandom);
            if (n == 300) rst = 1'b1;
            if (n == 302) rst = 1'b0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
